// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if -- bus bundle for the multi-port register file.
//
// Parameters: DATA_W (data width), ADDR_W (address width), NRD (read ports).
//
// Signals:
//   re       [NRD]          per-port read enable
//   raddr    [NRD*ADDR_W]   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata    [NRD*DATA_W]   read data, port i at [i*DATA_W +: DATA_W]
//   we0/we1                 write enables, write ports 0 and 1
//   waddr0/waddr1 [ADDR_W]  write addresses
//   wdata0/wdata1 [DATA_W]  write data
//   clr_req                 request to zero the whole file
//   busy                    clear sequence in progress
//   clr_done                one-cycle pulse when the clear completes
//
// Handshake: busy is the only flow control. A write or clr_req is accepted at
// a rising edge only when busy is low at that edge; while busy is high the
// master must stall, because anything it presents is discarded without
// notice. Reads carry no handshake: rdata is combinational from re/raddr.
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD-1:0]        re;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic                  we0;
    logic                  we1;
    logic [ADDR_W-1:0]     waddr0;
    logic [ADDR_W-1:0]     waddr1;
    logic [DATA_W-1:0]     wdata0;
    logic [DATA_W-1:0]     wdata1;
    logic                  clr_req;
    logic                  busy;
    logic                  clr_done;

    modport master (
        output re, raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, clr_req,
        input  rdata, busy, clr_done
    );

    modport slave (
        input  re, raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, clr_req,
        output rdata, busy, clr_done
    );
endinterface

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- register file with NRD combinational read ports, two write
// ports and a sequential whole-file clear.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset; zeroes every register
//   bus        regfile_mp_if.slave (read/write/clear bundle)
//   fsm_state  debug view of the clear FSM: 0 = IDLE, 1 = CLEAR
//
// Register 0 is hard-wired to read as zero and is never written.
// Write port 1 has priority over port 0 on an address collision.
// A clear walks index 1..DEPTH-1, zeroing one register per cycle; busy is
// high for DEPTH-1 cycles and clr_done pulses in the first IDLE cycle after.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to matching read ports. Without it a write becomes visible in the
// cycle after it commits.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus,
    output logic          fsm_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic              busy;
    logic              clr_done;

    logic [DATA_W-1:0] regs [DEPTH];

    logic [NRD*DATA_W-1:0] rdata;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_val;

    // Writes are accepted only in IDLE and only when no clear is being
    // requested at the same edge: the clear takes precedence.
    logic wr_ok;
    assign wr_ok = (state == IDLE) && !bus.clr_req;

    // -----------------------------------------------------------------------
    // Clear FSM. busy and clr_done are registered alongside the state so that
    // busy == (state == CLEAR) at all times.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            index    <= FIRST_IDX;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state <= CLEAR;
                        index <= FIRST_IDX;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_req is deliberately not looked at here: a request
                    // arriving mid-clear is absorbed by the running sequence.
                    if (index == LAST_IDX) begin
                        state    <= IDLE;
                        index    <= FIRST_IDX;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        index <= index + FIRST_IDX;
                    end
                end
                default: begin
                    state <= IDLE;
                    index <= FIRST_IDX;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage. Port 1 is assigned after port 0 so it wins on a collision.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[index] <= '0;
        end else if (wr_ok) begin
            if (bus.we0 && (bus.waddr0 != '0)) begin
                regs[bus.waddr0] <= bus.wdata0;
            end
            if (bus.we1 && (bus.waddr1 != '0)) begin
                regs[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports. Each port is resolved independently from the same array,
    // so two ports on one address always see the same value.
    // -----------------------------------------------------------------------
    always_comb begin
        rdata   = '0;
        rd_addr = '0;
        rd_val  = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_addr = bus.raddr[i*ADDR_W +: ADDR_W];
            rd_val  = '0;
            if (!rst && bus.re[i] && (rd_addr != '0) && !busy) begin
                rd_val = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
                // Forward the value that will be stored at the coming edge;
                // port 1 is checked first to mirror its write priority.
                if (bus.we1 && (bus.waddr1 == rd_addr)) begin
                    rd_val = bus.wdata1;
                end else if (bus.we0 && (bus.waddr0 == rd_addr)) begin
                    rd_val = bus.wdata0;
                end
`else
`endif
            end
            rdata[i*DATA_W +: DATA_W] = rd_val;
        end
    end

    assign bus.rdata    = rdata;
    assign bus.busy     = busy;
    assign bus.clr_done = clr_done;
    assign fsm_state    = (state == CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (default parameters).
// The reference model keeps the file as a plain array and treats a clear as
// "everything becomes zero at once, then the file is unavailable for DEPTH-1
// cycles", which is all that is observable from the ports.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic fsm_state;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fails  = 0;
    logic [DW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    int            m_busy_left = 0;
    bit            m_done      = 1'b0;

    function automatic logic [DW-1:0] model_read(input int p);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = bus.raddr[p*AW +: AW];
        if (rst || !bus.re[p] || a == 0 || m_busy_left > 0) return '0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (bus.we1 && bus.waddr1 == a) v = bus.wdata1;
        else if (bus.we0 && bus.waddr0 == a) v = bus.wdata0;
`endif
        return v;
    endfunction

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_edge();
        m_done = 1'b0;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_busy_left = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_done = 1'b1;
        end else if (bus.clr_req) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_busy_left = DEPTH - 1;
        end else begin
            if (bus.we0 && bus.waddr0 != 0) m_mem[bus.waddr0] = bus.wdata0;
            if (bus.we1 && bus.waddr1 != 0) m_mem[bus.waddr1] = bus.wdata1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [DW-1:0] obs);
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic expect_val(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] e);
        exp_q.push_back(e);
        check(tag, obs);
    endtask

    // Check every output against the model, then advance one clock.
    task automatic cycle();
        #1;
        for (int p = 0; p < NR; p++) begin
            exp_q.push_back(model_read(p));
            check($sformatf("rdata%0d", p), bus.rdata[p*DW +: DW]);
        end
        exp_q.push_back(DW'(m_busy_left > 0));
        check("busy", DW'(bus.busy));
        exp_q.push_back(DW'(m_done));
        check("clr_done", DW'(bus.clr_done));
        exp_q.push_back(DW'(m_busy_left > 0));
        check("fsm_state", DW'(fsm_state));
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.re      = '0;
        bus.raddr   = '0;
        bus.we0     = 1'b0;
        bus.we1     = 1'b0;
        bus.waddr0  = '0;
        bus.waddr1  = '0;
        bus.wdata0  = '0;
        bus.wdata1  = '0;
        bus.clr_req = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.re[p]            = 1'b1;
        bus.raddr[p*AW +: AW] = a;
    endtask

    task automatic set_wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we0 = 1'b1; bus.waddr0 = a; bus.wdata0 = d;
    endtask

    task automatic set_wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we1 = 1'b1; bus.waddr1 = a; bus.wdata1 = d;
    endtask

    task automatic drive_random(input bit allow_clr);
        bus.re      = NR'($urandom_range(0, (1 << NR) - 1));
        bus.raddr   = (NR*AW)'($urandom);
        bus.we0     = $urandom_range(0, 1) == 1;
        bus.we1     = $urandom_range(0, 1) == 1;
        bus.waddr0  = AW'($urandom_range(0, DEPTH - 1));
        bus.waddr1  = ($urandom_range(0, 3) == 0) ? bus.waddr0
                                                  : AW'($urandom_range(0, DEPTH - 1));
        bus.wdata0  = $urandom;
        bus.wdata1  = $urandom;
        // Bias one read port onto a write address to exercise collisions.
        if ($urandom_range(0, 1) == 1) bus.raddr[AW-1:0] = bus.waddr1;
        bus.clr_req = allow_clr && ($urandom_range(0, 99) == 0);
    endtask

    task automatic fill_all();
        for (int a = 1; a < DEPTH; a++) begin
            drive_idle();
            set_wr0(AW'(a), 32'hA500_0000 | DW'(a));
            cycle();
        end
        drive_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        rst = 1'b1;
        drive_idle();
        model_edge();
        @(posedge clk);
        #1;

        // Reset state, with reads and writes presented during reset.
        set_rd(0, 5'd5); set_rd(1, 5'd9);
        set_wr0(5'd5, 32'h1111_1111);
        bus.clr_req = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        drive_idle();
        set_rd(0, 5'd5);
        #1;
        expect_val("reset_reg5", bus.rdata[DW-1:0], 32'h0);
        cycle();

        // Basic write then read, and register 0 is immune to writes.
        drive_idle();
        set_wr0(5'd5, 32'hDEAD_BEEF);
        cycle();
        drive_idle();
        set_rd(0, 5'd5);
        #1;
        expect_val("read_reg5", bus.rdata[DW-1:0], 32'hDEAD_BEEF);
        cycle();
        drive_idle();
        set_wr0(5'd0, 32'h0000_1234);
        cycle();
        drive_idle();
        set_rd(0, 5'd0);
        #1;
        expect_val("read_reg0", bus.rdata[DW-1:0], 32'h0);
        cycle();

        // Write collision: port 1 wins; both read ports agree.
        drive_idle();
        set_wr0(5'd7, 32'hAAAA_0000);
        set_wr1(5'd7, 32'h0000_BBBB);
        cycle();
        drive_idle();
        set_rd(0, 5'd7); set_rd(1, 5'd7);
        #1;
        expect_val("collide_p0", bus.rdata[DW-1:0], 32'h0000_BBBB);
        expect_val("collide_p1", bus.rdata[2*DW-1:DW], 32'h0000_BBBB);
        cycle();

        // Same-cycle read of a register being written.
        drive_idle();
        set_wr0(5'd3, 32'h0000_0011);
        cycle();
        drive_idle();
        set_wr1(5'd3, 32'h0000_0055);
        set_rd(1, 5'd3);
        #1;
`ifdef REGFILE_BYPASS_EN
        expect_val("bypass_p1", bus.rdata[2*DW-1:DW], 32'h0000_0055);
`else
        expect_val("bypass_p1", bus.rdata[2*DW-1:DW], 32'h0000_0011);
`endif
        cycle();
        drive_idle();
        set_rd(1, 5'd3);
        #1;
        expect_val("after_bypass", bus.rdata[2*DW-1:DW], 32'h0000_0055);
        cycle();

        // Random traffic, occasional clears and resets.
        for (int k = 0; k < 300; k++) begin
            drive_random(1'b1);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        drive_idle();
        cnt = 0;
        while (bus.busy && cnt < 40) begin
            cycle();
            cnt++;
        end
        expect_val("drain_busy", DW'(bus.busy), 32'h0);

        // Full clear: fill, request with a concurrent write, write during busy.
        fill_all();
        set_wr0(5'd4, 32'hFFFF_FFFF);
        bus.clr_req = 1'b1;
        cycle();
        cnt = 0;
        while (bus.busy && cnt < 40) begin
            drive_random(1'b1);
            bus.re = '1;
            cycle();
            cnt++;
        end
        expect_val("busy_cycles", DW'(cnt), 32'd31);
        expect_val("clr_done_pulse", DW'(bus.clr_done), 32'h1);
        for (int a = 0; a < DEPTH; a += 2) begin
            drive_idle();
            set_rd(0, AW'(a)); set_rd(1, AW'(a + 1));
            #1;
            expect_val("cleared_p0", bus.rdata[DW-1:0], 32'h0);
            expect_val("cleared_p1", bus.rdata[2*DW-1:DW], 32'h0);
            cycle();
        end

        // Reset in the middle of a clear.
        fill_all();
        bus.clr_req = 1'b1;
        cycle();
        drive_idle();
        for (int k = 0; k < 10; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        expect_val("abort_busy", DW'(bus.busy), 32'h0);
        expect_val("abort_no_done", DW'(bus.clr_done), 32'h0);
        cycle();
        expect_val("abort_still_no_done", DW'(bus.clr_done), 32'h0);
        for (int a = 1; a < DEPTH; a++) begin
            drive_idle();
            set_rd(0, AW'(a));
            #1;
            expect_val("abort_zero", bus.rdata[DW-1:0], 32'h0);
            cycle();
        end
        drive_idle();
        set_wr0(5'd9, 32'h0000_0009);
        cycle();
        drive_idle();
        set_rd(0, 5'd9);
        #1;
        expect_val("post_abort_write", bus.rdata[DW-1:0], 32'h0000_0009);
        cycle();

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
